uart_rx: RTL

UART receiver that consumes the serial line driven by the team's UART transmitter. It oversamples RX_IN at PRESCALE clocks per bit and majority-votes each bit. It deserialises start/data/optional parity/stop frames, LSB first, and presents the parallel word with a one-cycle valid pulse plus parity and stop error flags. Frame format and parity options match the transmitter: PAR_EN enables parity, PAR_TYP 0 = even, 1 = odd.

---
 rtl/uart_rx.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with majority vote, optional parity and stop checking
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int EW = $clog2(PRESCALE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [EW-1:0] S0_CNT   = EW'(PRESCALE/2 - 1);
    localparam logic [EW-1:0] S1_CNT   = EW'(PRESCALE/2);
    localparam logic [EW-1:0] DEC_CNT  = EW'(PRESCALE/2 + 1);
    localparam logic [EW-1:0] LAST_CNT = EW'(PRESCALE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state_q;
    logic                    rx_meta_q, rx_s_q;
    logic [EW-1:0]           edge_cnt_q;
    logic [BW-1:0]           bit_cnt_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    samp0_q, samp1_q;
    logic                    par_en_q, par_typ_q, par_bad_q;

    logic                    maj;
    logic                    is_dec, is_last;
    logic [DATA_WIDTH:0]     shift_ext;
    logic [DATA_WIDTH-1:0]   shift_d;

    always_comb begin
        maj       = (samp0_q & samp1_q) | (samp0_q & rx_s_q) | (samp1_q & rx_s_q);
        is_dec    = (edge_cnt_q == DEC_CNT);
        is_last   = (edge_cnt_q == LAST_CNT);
        // LSB arrives first, so new bits enter at the top and drift down
        shift_ext = {maj, shift_q};
        shift_d   = shift_ext[DATA_WIDTH:1];
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '1;
            samp0_q    <= 1'b1;
            samp1_q    <= 1'b1;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            rx_meta_q  <= RX_IN;
            rx_s_q     <= rx_meta_q;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            if (state_q != IDLE) begin
                edge_cnt_q <= is_last ? '0 : edge_cnt_q + 1'b1;
            end
            if (edge_cnt_q == S0_CNT) samp0_q <= rx_s_q;
            if (edge_cnt_q == S1_CNT) samp1_q <= rx_s_q;

            case (state_q)
                IDLE: begin
                    edge_cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q   <= START;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        par_bad_q <= 1'b0;
                        bit_cnt_q <= '0;
                    end
                end
                START: begin
                    if (is_dec && maj) begin
                        state_q <= IDLE;
                    end else if (is_last) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (is_dec) shift_q <= shift_d;
                    if (is_last) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (is_dec) par_bad_q <= (maj != ((^shift_q) ^ par_typ_q));
                    if (is_last) state_q <= STOP;
                end
                STOP: begin
                    // Leave at the decision point so a start bit right after the stop bit is caught
                    if (is_dec) begin
                        state_q <= IDLE;
                        STP_ERR <= ~maj;
                        PAR_ERR <= par_bad_q;
                        if (maj && !par_bad_q) begin
                            P_DATA     <= shift_q;
                            DATA_VALID <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
